// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT constants, FSM states and layer functions.
// Layer functions work on a MAXW-wide vector and a run-time width w.
package present_pkg;

  localparam int RC_W = 5;
  localparam int MAXW = 128;
  localparam int IDXW = $clog2(MAXW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WHITEN,
    OUT
  } fsm_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB,
    4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8,
    4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [MAXW-1:0] sbox_layer(
    input logic [MAXW-1:0] x,
    input int unsigned     w
  );
    logic [MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAXW / 4; i++) begin
      if (4 * i < w) begin
        r[4*i+:4] = SBOX[x[4*i+:4]];
      end
    end
    return r;
  endfunction

  // Bit i goes to (i*w/4) mod (w-1); the top bit stays put.
  function automatic logic [MAXW-1:0] p_layer(
    input logic [MAXW-1:0] x,
    input int unsigned     w
  );
    logic [MAXW-1:0] r;
    logic [IDXW-1:0] idx;
    r = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i + 1 < w) begin
        idx = IDXW'((i * w / 4) % (w - 1));
        r[idx] = x[i];
      end else if (i + 1 == w) begin
        r[i] = x[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/present_iter_core_if.sv
// present_iter_core_if: plaintext/key input and ciphertext output handshakes.
// master = source/consumer side, slave = cipher core side.
interface present_iter_core_if #(
  parameter int DATAW = 64,
  parameter int KEYW  = 80
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [DATAW-1:0] ptext_i;
  logic [KEYW-1:0]  key_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [DATAW-1:0] cipher_o;

  modport master (
    output in_valid_i,
    output ptext_i,
    output key_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  cipher_o
  );

  modport slave (
    input  in_valid_i,
    input  ptext_i,
    input  key_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output cipher_o
  );

endinterface

// File: rtl/present_key_sched.sv
// present_key_sched: combinational key update(key, rc) and round key tap.
// Ports: key_i/rc_i in; key_o = next key, rk_o = key[KEYW-1 -: DATAW].
module present_key_sched
  import present_pkg::*;
#(
  parameter int KEYW  = 80,
  parameter int DATAW = 64
) (
  input  logic [KEYW-1:0]  key_i,
  input  logic [RC_W-1:0]  rc_i,
  output logic [KEYW-1:0]  key_o,
  output logic [DATAW-1:0] rk_o
);

  logic [KEYW-1:0] rot;

  // Rotate left by KEYW-19.
  assign rot  = {key_i[18:0], key_i[KEYW-1:19]};
  assign rk_o = key_i[KEYW-1 -: DATAW];

  // Steps applied in order; with KEYW=20 the nibble and rc fields overlap.
  always_comb begin
    key_o              = rot;
    key_o[KEYW-1 -: 4] = SBOX[rot[KEYW-1 -: 4]];
    key_o[19:15]       = key_o[19:15] ^ rc_i;
  end

endmodule

// File: rtl/present_iter_core.sv
// present_iter_core: iterative PRESENT encryption, one round per cycle.
// Ports: clk_i, rst_ni (sync, low), bus (slave), abort_i if PRESENT_ABORT_EN.
module present_iter_core
  import present_pkg::*;
#(
  parameter int DATAW   = 64,
  parameter int KEYW    = 80,
  parameter int NROUNDS = 31
) (
  input logic clk_i,
  input logic rst_ni,
  present_iter_core_if.slave bus
`ifdef PRESENT_ABORT_EN
  ,
  input logic abort_i
`endif
);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NROUNDS);

  fsm_e             fsm_q;
  logic [DATAW-1:0] st_q;
  logic [DATAW-1:0] cipher_q;
  logic [KEYW-1:0]  key_q;
  logic [RC_W-1:0]  rc_q;
  logic             vld_q;

  logic [KEYW-1:0]  key_nxt;
  logic [DATAW-1:0] rk;
  logic [DATAW-1:0] rnd;
  logic             abort;

`ifdef PRESENT_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  present_key_sched #(
    .KEYW  (KEYW),
    .DATAW (DATAW)
  ) u_ks (
    .key_i (key_q),
    .rc_i  (rc_q),
    .key_o (key_nxt),
    .rk_o  (rk)
  );

  assign rnd = DATAW'(p_layer(
                 sbox_layer(MAXW'(st_q ^ rk), DATAW),
                 DATAW));

  assign bus.in_ready_o  = (fsm_q == IDLE);
  assign bus.out_valid_o = vld_q;
  assign bus.cipher_o    = cipher_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fsm_q    <= IDLE;
      st_q     <= '0;
      key_q    <= '0;
      rc_q     <= '0;
      cipher_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            st_q  <= bus.ptext_i;
            key_q <= bus.key_i;
            rc_q  <= RC_W'(1);
            fsm_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            rc_q  <= '0;
            fsm_q <= IDLE;
          end else begin
            st_q  <= rnd;
            key_q <= key_nxt;
            // rc is parked at 0 rather than wrapping past NROUNDS.
            if (rc_q == RC_LAST) begin
              rc_q  <= '0;
              fsm_q <= WHITEN;
            end else begin
              rc_q <= rc_q + 1'b1;
            end
          end
        end
        WHITEN: begin
          if (abort) begin
            rc_q  <= '0;
            fsm_q <= IDLE;
          end else begin
            cipher_q <= st_q ^ rk;
            vld_q    <= 1'b1;
            fsm_q    <= OUT;
          end
        end
        OUT: begin
          if (bus.out_ready_i) begin
            vld_q <= 1'b0;
            fsm_q <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_iter_core.sv
// tb_present_iter_core: directed vectors for 64/80 and 32/80 PRESENT cores.
// Checks latency, backpressure, reset abort, back-to-back spacing.
module tb_present_iter_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] TSB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  present_iter_core_if #(.DATAW(64), .KEYW(80)) b64 ();
  present_iter_core_if #(.DATAW(32), .KEYW(80)) b32 ();

`ifdef PRESENT_ABORT_EN
  logic ab64 = 1'b0;
  logic ab32 = 1'b0;
`endif

  present_iter_core #(
    .DATAW(64), .KEYW(80), .NROUNDS(31)
  ) u64 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b64.slave)
`ifdef PRESENT_ABORT_EN
    ,
    .abort_i(ab64)
`endif
  );

  present_iter_core #(
    .DATAW(32), .KEYW(80), .NROUNDS(31)
  ) u32 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b32.slave)
`ifdef PRESENT_ABORT_EN
    ,
    .abort_i(ab32)
`endif
  );

  typedef struct {
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref32(input logic [31:0] pt,
                                        input logic [79:0] k);
    logic [31:0] s;
    logic [31:0] t;
    logic [79:0] kk;
    s  = pt;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:48];
      for (int n = 0; n < 8; n++) s[4*n+:4] = TSB[s[4*n+:4]];
      t = '0;
      for (int i = 0; i < 31; i++) t[(i * 8) % 31] = s[i];
      t[31] = s[31];
      s = t;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = TSB[kk[79:76]];
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:48];
  endfunction

  task automatic start64(input logic [63:0] pt, input logic [79:0] key,
                         input string nm);
    int lat;
    b64.ptext_i    = pt;
    b64.key_i      = key;
    b64.in_valid_i = 1'b1;
    tick();
    b64.in_valid_i = 1'b0;
    lat = 0;
    while (b64.out_valid_o !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd32);
  endtask

  task automatic release64(input string nm);
    b64.out_ready_i = 1'b1;
    tick();
    b64.out_ready_i = 1'b0;
    chk({nm, " in_ready after OUT"}, 64'(b64.in_ready_o), 64'd1);
    chk({nm, " out_valid after OUT"}, 64'(b64.out_valid_o), 64'd0);
  endtask

  task automatic run64(input vec_t v, input string nm);
    start64(v.pt, v.key, nm);
    chk({nm, " cipher"}, b64.cipher_o, v.ct);
    release64(nm);
  endtask

  task automatic quiet64(input int n, input string nm);
    int seen;
    seen = 0;
    repeat (n) begin
      tick();
      if (b64.out_valid_o !== 1'b0) seen++;
    end
    chk({nm, " no out_valid"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] p32 [3];
    logic [79:0] k32 [3];
    int unsigned acc [3];
    int w;

    vt[0] = '{64'h0, 80'h0, 64'h5579C1387B228445};
    vt[1] = '{64'h0, {80{1'b1}}, 64'hE72C46C0F5945049};
    vt[2] = '{{64{1'b1}}, 80'h0, 64'hA112FFC72F68417B};
    vt[3] = '{{64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2};

    p32[0] = 32'h0;
    k32[0] = 80'h0;
    p32[1] = 32'hFFFF_FFFF;
    k32[1] = {80{1'b1}};
    p32[2] = 32'h0123_4567;
    k32[2] = 80'h89AB_CDEF_0123_4567_89AB;

    b64.in_valid_i  = 1'b0;
    b64.ptext_i     = '0;
    b64.key_i       = '0;
    b64.out_ready_i = 1'b0;
    b32.in_valid_i  = 1'b0;
    b32.ptext_i     = '0;
    b32.key_i       = '0;
    b32.out_ready_i = 1'b0;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset out_valid", 64'(b64.out_valid_o), 64'd0);
    chk("reset cipher", b64.cipher_o, 64'd0);
    chk("reset in_ready", 64'(b64.in_ready_o), 64'd1);
    chk("reset out_valid32", 64'(b32.out_valid_o), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run64(vt[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold OUT for 10 cycles while a new block is offered.
    start64(vt[0].pt, vt[0].key, "bp");
    b64.ptext_i    = {64{1'b1}};
    b64.key_i      = {80{1'b1}};
    b64.in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp hold cipher %0d", i), b64.cipher_o, vt[0].ct);
      chk($sformatf("bp hold valid %0d", i),
          64'(b64.out_valid_o), 64'd1);
      chk($sformatf("bp in_ready %0d", i), 64'(b64.in_ready_o), 64'd0);
    end
    b64.in_valid_i = 1'b0;
    release64("bp");
    chk("bp cipher kept", b64.cipher_o, vt[0].ct);

    // Reset in the middle of a run.
    b64.ptext_i    = vt[2].pt;
    b64.key_i      = vt[2].key;
    b64.in_valid_i = 1'b1;
    tick();
    b64.in_valid_i = 1'b0;
    repeat (11) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst in_ready", 64'(b64.in_ready_o), 64'd1);
    chk("midrst out_valid", 64'(b64.out_valid_o), 64'd0);
    chk("midrst cipher", b64.cipher_o, 64'd0);
    quiet64(40, "midrst");
    run64(vt[3], "postrst");

`ifdef PRESENT_ABORT_EN
    b64.ptext_i    = vt[0].pt;
    b64.key_i      = vt[0].key;
    b64.in_valid_i = 1'b1;
    tick();
    b64.in_valid_i = 1'b0;
    repeat (4) tick();
    ab64 = 1'b1;
    tick();
    ab64 = 1'b0;
    chk("abort in_ready", 64'(b64.in_ready_o), 64'd1);
    chk("abort out_valid", 64'(b64.out_valid_o), 64'd0);
    chk("abort cipher kept", b64.cipher_o, vt[3].ct);
    quiet64(40, "abort");
    start64(vt[1].pt, vt[1].key, "abort_out");
    ab64 = 1'b1;
    tick();
    ab64 = 1'b0;
    chk("abort_out valid", 64'(b64.out_valid_o), 64'd1);
    chk("abort_out in_ready", 64'(b64.in_ready_o), 64'd0);
    chk("abort_out cipher", b64.cipher_o, vt[1].ct);
    release64("abort_out");
`endif

    // 32-bit core, back-to-back with the consumer always ready.
    b32.out_ready_i = 1'b1;
    b32.in_valid_i  = 1'b1;
    for (int b = 0; b < 3; b++) begin
      w = 0;
      while (b32.in_ready_o !== 1'b1 && w < 60) begin
        tick();
        w++;
      end
      chk($sformatf("b2b%0d ready wait", b), 64'(w < 60), 64'd1);
      b32.ptext_i = p32[b];
      b32.key_i   = k32[b];
      tick();
      acc[b] = cyc;
      w = 0;
      while (b32.out_valid_o !== 1'b1 && w < 60) begin
        tick();
        w++;
      end
      chk($sformatf("b2b%0d latency", b), 64'(w), 64'd32);
      chk($sformatf("b2b%0d cipher", b), 64'(b32.cipher_o),
          64'(ref32(p32[b], k32[b])));
      if (b > 0) begin
        chk($sformatf("b2b%0d spacing", b),
            64'(acc[b] - acc[b-1]), 64'd34);
      end
    end
    b32.in_valid_i = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
